mdu_ex: RTL and testbench

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and performs MTHI/MTLO as single-cycle writes. It produces the `busy`-based stall request that the hazard unit ORs into `stall_PC`, `stall_IF` and `clr_EX`. An MD-class instruction in ID therefore never reaches EX while a previous operation is in flight.

---
 rtl/mdu_ex_if.sv | 15 +
 rtl/mdu_ex.sv | 95 +++++++++
 tb/tb_mdu_ex.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_ex_if.sv
// mdu_ex_if: EX-stage multiply/divide unit bus between pipeline and HI/LO unit.
interface mdu_ex_if;
  logic        start;
  logic [2:0]  op;
  logic        wr_en;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_ID;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;
  modport master(output start, op, wr_en, src_a, src_b, md_use_ID, input hi, lo, busy, stall_md);
  modport slave(input start, op, wr_en, src_a, src_b, md_use_ID, output hi, lo, busy, stall_md);
endinterface

// File: rtl/mdu_ex.sv
// mdu_ex: HI/LO owner executing MULT/MULTU/DIV/DIVU with fixed latency and MTHI/MTLO writes.
// The result is computed at issue and held pending until the latency counter expires.
module mdu_ex #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  mdu_ex_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [31:0] r_hi, r_lo, r_p_hi, r_p_lo;
  logic [31:0] w_hi_n, w_lo_n, w_p_hi_n, w_p_lo_n;
  logic        r_p_we, w_p_we_n, r_busy, w_busy_n;
  logic        w_is_md, w_is_div, w_sgn, w_dz, w_a_neg, w_b_neg;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [31:0] w_da, w_db, w_dv, w_uq, w_ur, w_q, w_r;
  assign w_is_md  = bus.start && !bus.op[2];
  assign w_is_div = bus.op[1];
  assign w_sgn    = !bus.op[0];
  assign w_ma     = {{32{w_sgn & bus.src_a[31]}}, bus.src_a};
  assign w_mb     = {{32{w_sgn & bus.src_b[31]}}, bus.src_b};
  assign w_prod   = w_ma * w_mb;
  // Signed divide works on magnitudes so 0x80000000 / -1 needs no overflow special case
  assign w_a_neg  = w_sgn & bus.src_a[31];
  assign w_b_neg  = w_sgn & bus.src_b[31];
  assign w_da     = w_a_neg ? -bus.src_a : bus.src_a;
  assign w_db     = w_b_neg ? -bus.src_b : bus.src_b;
  assign w_dz     = bus.src_b == 32'd0;
  assign w_dv     = w_dz ? 32'd1 : w_db;
  assign w_uq     = w_da / w_dv;
  assign w_ur     = w_da % w_dv;
  assign w_q      = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
  assign w_r      = w_a_neg ? -w_ur : w_ur;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_p_hi_n  = r_p_hi;
    w_p_lo_n  = r_p_lo;
    w_p_we_n  = r_p_we;
    w_busy_n  = r_busy;
    if (r_state == IDLE) begin
      if (w_is_md) begin
        w_state_n = RUN;
        w_busy_n  = 1'b1;
        w_cnt_n   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        w_p_hi_n  = w_is_div ? w_r : w_prod[63:32];
        w_p_lo_n  = w_is_div ? w_q : w_prod[31:0];
        w_p_we_n  = !(w_is_div && w_dz);
      end else if (bus.wr_en) begin
        w_hi_n = (bus.op == 3'd4) ? bus.src_a : r_hi;
        w_lo_n = (bus.op == 3'd5) ? bus.src_a : r_lo;
      end
    end else begin
      w_cnt_n = r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
        w_hi_n    = r_p_we ? r_p_hi : r_hi;
        w_lo_n    = r_p_we ? r_p_lo : r_lo;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_p_we  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_p_hi  <= w_p_hi_n;
      r_p_lo  <= w_p_lo_n;
      r_p_we  <= w_p_we_n;
      r_busy  <= w_busy_n;
    end
  end
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.stall_md = bus.md_use_ID & (bus.start | r_busy);
endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: directed checks of mdu_ex results, latency, stall and reset behaviour.
module tb_mdu_ex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  mdu_ex_if bus();
  mdu_ex #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    bus.op    = 3'd6;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    bus.wr_en = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    tick();
    bus.wr_en = 1'b0;
    bus.op    = 3'd6;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bus.op    = 3'($urandom_range(0, 7));
      bus.src_a = $urandom;
      bus.src_b = $urandom;
      bus.wr_en = 1'($urandom_range(0, 1));
      bus.md_use_ID = 1'($urandom_range(0, 1));
      bus.start = 1'b0;
      tick();
    end
    total++; if (bus.hi !== 32'd0) $display("FAIL reset_hi got=%h exp=0", bus.hi); else passed++;
    total++; if (bus.lo !== 32'd0) $display("FAIL reset_lo got=%h exp=0", bus.lo); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    bus.md_use_ID = 1'b1;
    #1;
    total++; if (bus.stall_md !== 1'b0) $display("FAIL reset_stall_nostart got=%b exp=0", bus.stall_md); else passed++;
    bus.start = 1'b1;
    #1;
    total++; if (bus.stall_md !== 1'b1) $display("FAIL reset_stall_start got=%b exp=1", bus.stall_md); else passed++;
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.md_use_ID = 1'b0; bus.op = 3'd6;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) $display("FAIL mult_early got=%h_%h exp=0_0", bus.hi, bus.lo); else passed++;
    wait_idle(n);
    total++; if (n !== 5) $display("FAIL mult_busy_cycles got=%0d exp=5", n); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFEB) $display("FAIL mult_lo got=%h exp=ffffffeb", bus.lo); else passed++;
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    total++; if (n !== 5) $display("FAIL multu_busy_cycles got=%0d exp=5", n); else passed++;
    total++; if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFFFFFE) $display("FAIL multu_result got=%h_%h exp=00000001_fffffffe", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++; if (n !== 10) $display("FAIL div_busy_cycles got=%0d exp=10", n); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFFD) $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFF) $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); else passed++;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'd0) $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", bus.hi, bus.lo); else passed++;
    issue(3'd3, 32'hFFFFFFFF, 32'd16);
    wait_idle(n);
    total++; if (bus.lo !== 32'h0FFFFFFF || bus.hi !== 32'd15) $display("FAIL divu_result got=%h_%h exp=0000000f_0fffffff", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_div_zero();
    int n;
    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    total++; if (n !== 10) $display("FAIL divz_busy_cycles got=%0d exp=10", n); else passed++;
    total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) $display("FAIL divz_unchanged got=%h_%h exp=00000011_00000022", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_stall();
    int s;
    bus.md_use_ID = 1'b1;
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd5;
    #1;
    s = (bus.stall_md === 1'b1) ? 1 : 0;
    tick();
    bus.start = 1'b0; bus.op = 3'd6;
    for (int i = 0; i < 30 && bus.busy === 1'b1; i++) begin
      if (bus.stall_md === 1'b1) s++;
      tick();
    end
    total++; if (s !== 6) $display("FAIL stall_cycles got=%0d exp=6", s); else passed++;
    total++; if (bus.stall_md !== 1'b0) $display("FAIL stall_at_update got=%b exp=0", bus.stall_md); else passed++;
    total++; if (bus.lo !== 32'd15) $display("FAIL stall_mult_lo got=%h exp=0000000f", bus.lo); else passed++;
    bus.md_use_ID = 1'b0;
  endtask

  task automatic test_mt();
    mt(3'd5, 32'h12345678);
    total++; if (bus.lo !== 32'h12345678) $display("FAIL mtlo_lo got=%h exp=12345678", bus.lo); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL mtlo_busy got=%b exp=0", bus.busy); else passed++;
    mt(3'd4, 32'hCAFEF00D);
    total++; if (bus.hi !== 32'hCAFEF00D || bus.lo !== 32'h12345678) $display("FAIL mthi_result got=%h_%h exp=cafef00d_12345678", bus.hi, bus.lo); else passed++;
    issue(3'd4, 32'h5555, 32'd0);
    total++; if (bus.busy !== 1'b0 || bus.hi !== 32'hCAFEF00D) $display("FAIL start_op4_ignored busy=%b hi=%h exp=0,cafef00d", bus.busy, bus.hi); else passed++;
  endtask

  task automatic test_start_over_wr();
    int n;
    bus.wr_en = 1'b1;
    issue(3'd0, 32'd3, 32'd4);
    bus.wr_en = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.hi !== 32'hCAFEF00D) $display("FAIL start_prio busy=%b hi=%h exp=1,cafef00d", bus.busy, bus.hi); else passed++;
    wait_idle(n);
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd12) $display("FAIL start_prio_result got=%h_%h exp=00000000_0000000c", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd0, 32'd6, 32'd7);
    issue(3'd0, 32'd9, 32'd9);
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_run_ignore_busy got=%b exp=1", bus.busy); else passed++;
    wait_idle(n);
    total++; if (n !== 4 || bus.lo !== 32'd42) $display("FAIL b2b_first n=%0d lo=%h exp=4,0000002a", n, bus.lo); else passed++;
    issue(3'd0, 32'h10000, 32'h10000);
    wait_idle(n);
    total++; if (n !== 5 || bus.hi !== 32'd1 || bus.lo !== 32'd0) $display("FAIL b2b_second n=%0d got=%h_%h exp=5,00000001_00000000", n, bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_reset_mid_op();
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) $display("FAIL midrst_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); else passed++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) $display("FAIL midrst_nowrite got=%h_%h busy=%b exp=0_0,0", bus.hi, bus.lo, bus.busy); else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd6; bus.wr_en = 1'b0;
    bus.src_a = '0; bus.src_b = '0; bus.md_use_ID = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_mt();
    test_start_over_wr();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
